// File: rtl/dma_burst_gen_pkg.sv
// rtl/dma_burst_gen_pkg.sv - shared types, constants and strobe helper for the DMA burst generator
// Purpose: burst encodings, FSM state type, 4 KB boundary constant and a
// byte-strobe range builder used by the burst calculator.
package dma_burst_gen_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01
    } dma_burst_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_DRAIN
    } dma_state_e;

    localparam int AXI_4KB  = 4096;
    localparam int STRB_MAX = 64;

    // Ones in bit positions lo..hi inclusive; callers narrow the result to BPB.
    function automatic logic [STRB_MAX-1:0] strb_range(input int lo, input int hi);
        logic [STRB_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < STRB_MAX; i++) begin
            r[i] = (i >= lo) && (i <= hi);
        end
        return r;
    endfunction

endpackage

// File: rtl/dma_burst_gen_if.sv
// rtl/dma_burst_gen_if.sv - AXI address-phase request channel for the burst generator
// Purpose: bundles the request handshake and burst fields.
// Ports (master view): req_valid/req_addr/req_alen/req_size/req_burst/req_write/
// req_first_strb/req_last_strb out, req_ready in.
interface dma_burst_gen_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BPB = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [7:0]            req_alen;
    logic [2:0]            req_size;
    logic [1:0]            req_burst;
    logic                  req_write;
    logic [BPB-1:0]        req_first_strb;
    logic [BPB-1:0]        req_last_strb;

    modport master (
        output req_valid, req_addr, req_alen, req_size, req_burst, req_write,
               req_first_strb, req_last_strb,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_alen, req_size, req_burst, req_write,
               req_first_strb, req_last_strb,
        output req_ready
    );

endinterface

// File: rtl/dma_burst_gen_calc.sv
// rtl/dma_burst_gen_calc.sv - combinational sizing of the next burst from the remaining descriptor
// Purpose: from current addr/bytes/mode/maxb derive aligned address, alen,
// bytes carried by the burst and first/last beat strobes.
// Ports: addr_i, bytes_i, mode_i (0 INCR, 1 FIXED), maxb_i in;
// addr_o, alen_o, bytes_this_o, first_strb_o, last_strb_o out.
module dma_burst_gen_calc
    import dma_burst_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BYTES_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [BYTES_WIDTH-1:0]  bytes_i,
    input  logic                    mode_i,
    input  logic [7:0]              maxb_i,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [7:0]              alen_o,
    output logic [BYTES_WIDTH-1:0]  bytes_this_o,
    output logic [DATA_WIDTH/8-1:0] first_strb_o,
    output logic [DATA_WIDTH/8-1:0] last_strb_o
);
    localparam int BPB = DATA_WIDTH / 8;
    localparam int LG  = $clog2(BPB);

    logic [LG-1:0] off;
    logic [LG-1:0] last_idx;
    logic [13:0]   off_w, bytes_sat, need, to4k, maxb1, fix_beats, beats, chunk;

    function automatic logic [13:0] min14(input logic [13:0] a, input logic [13:0] b);
        return (a < b) ? a : b;
    endfunction

    assign off    = addr_i[LG-1:0];
    assign off_w  = 14'(off);
    assign addr_o = {addr_i[ADDR_WIDTH-1:LG], {LG{1'b0}}};

    // Anything beyond 4 KB can never fit one burst, so saturating keeps 14 bits exact.
    assign bytes_sat = (bytes_i > BYTES_WIDTH'(AXI_4KB)) ? 14'(AXI_4KB) : 14'(bytes_i);
    assign need      = (off_w + bytes_sat + 14'(BPB - 1)) >> LG;
    assign to4k      = (14'(AXI_4KB) - {2'b00, addr_o[11:0]}) >> LG;
    assign maxb1     = {6'd0, maxb_i} + 14'd1;
    assign fix_beats = min14(min14(bytes_sat >> LG, maxb1), 14'd16);

    // FIXED with an unaligned address stays a single partial beat every time,
    // since the address never advances.
    always_comb begin
        beats = 14'd1;
        chunk = 14'(BPB) - off_w;
        if (mode_i == 1'b0) begin
            beats = min14(min14(need, maxb1), to4k);
            chunk = (beats << LG) - off_w;
        end else if (off == '0) begin
            if (fix_beats == 14'd0) begin
                beats = 14'd1;
                chunk = bytes_sat;
            end else begin
                beats = fix_beats;
                chunk = fix_beats << LG;
            end
        end
    end

    assign bytes_this_o = (BYTES_WIDTH'(chunk) < bytes_i) ? BYTES_WIDTH'(chunk) : bytes_i;
    assign alen_o       = 8'(beats - 14'd1);
    // Byte lane of the final byte; wraps modulo BPB by width.
    assign last_idx     = off + bytes_this_o[LG-1:0] - LG'(1);

    always_comb begin
        if (beats == 14'd1) begin
            first_strb_o = BPB'(strb_range(int'(off), int'(last_idx)));
            last_strb_o  = BPB'(strb_range(int'(off), int'(last_idx)));
        end else begin
            first_strb_o = BPB'(strb_range(int'(off), BPB - 1));
            last_strb_o  = BPB'(strb_range(0, int'(last_idx)));
        end
    end

endmodule

// File: rtl/dma_burst_gen.sv
// rtl/dma_burst_gen.sv - descriptor to AXI address-phase burst sequencer
// Purpose: splits one descriptor into 4 KB-safe bursts, limits outstanding
// bursts, drains on completion or abort.
// Ports: clk, rst; start_valid_i/start_ready_o/start_addr_i/start_bytes_i/
// start_mode_i/maxb_i descriptor in; abort_i; req_m request channel (master);
// txn_done_i; outst_o, done_o, aborted_o status out.
module dma_burst_gen
    import dma_burst_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BYTES_WIDTH = 32,
    parameter int MAX_OUTST   = 4,
    parameter int STREAM_TYPE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid_i,
    output logic                   start_ready_o,
    input  logic [ADDR_WIDTH-1:0]  start_addr_i,
    input  logic [BYTES_WIDTH-1:0] start_bytes_i,
    input  logic                   start_mode_i,
    input  logic [7:0]             maxb_i,
    input  logic                   abort_i,
    dma_burst_gen_if.master        req_m,
    input  logic                   txn_done_i,
    output logic [4:0]             outst_o,
    output logic                   done_o,
    output logic                   aborted_o
);
    localparam int BPB = DATA_WIDTH / 8;
    localparam int LG  = $clog2(BPB);

    dma_state_e             state_q, state_d;
    dma_burst_e             burst_q, burst_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d, raddr_q, raddr_d, c_addr;
    logic [BYTES_WIDTH-1:0] bytes_q, bytes_d, bt_q, bt_d, c_bt;
    logic [7:0]             maxb_q, maxb_d, alen_q, alen_d, c_alen;
    logic [BPB-1:0]         first_q, first_d, last_q, last_d, c_first, c_last;
    logic [4:0]             outst_q, outst_d;
    logic                   mode_q, mode_d, aborted_q, aborted_d;
    logic                   req_valid, accept, dec;

    dma_burst_gen_calc #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BYTES_WIDTH (BYTES_WIDTH)
    ) u_calc (
        .addr_i       (addr_q),
        .bytes_i      (bytes_q),
        .mode_i       (mode_q),
        .maxb_i       (maxb_q),
        .addr_o       (c_addr),
        .alen_o       (c_alen),
        .bytes_this_o (c_bt),
        .first_strb_o (c_first),
        .last_strb_o  (c_last)
    );

    // outst cannot rise while waiting for ready, so valid never drops once shown.
    assign req_valid = (state_q == ST_ISSUE) && (outst_q < 5'(MAX_OUTST));
    assign accept    = req_valid && req_m.req_ready;
    assign dec       = txn_done_i && (outst_q != 5'd0);
    assign outst_d   = outst_q + {4'd0, accept} - {4'd0, dec};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bytes_d   = bytes_q;
        mode_d    = mode_q;
        maxb_d    = maxb_q;
        aborted_d = aborted_q;
        raddr_d   = raddr_q;
        alen_d    = alen_q;
        burst_d   = burst_q;
        first_d   = first_q;
        last_d    = last_q;
        bt_d      = bt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid_i) begin
                    addr_d    = start_addr_i;
                    bytes_d   = start_bytes_i;
                    mode_d    = start_mode_i;
                    maxb_d    = maxb_i;
                    aborted_d = 1'b0;
                    state_d   = (start_bytes_i == '0) ? ST_DRAIN : ST_CALC;
                end
            end
            ST_CALC: begin
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else begin
                    raddr_d = c_addr;
                    alen_d  = c_alen;
                    burst_d = mode_q ? BURST_FIXED : BURST_INCR;
                    first_d = c_first;
                    last_d  = c_last;
                    bt_d    = c_bt;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    bytes_d = bytes_q - bt_q;
                    if (!mode_q) begin
                        addr_d = addr_q + ADDR_WIDTH'(bt_q);
                    end
                    if (abort_i || aborted_q || (bytes_q == bt_q)) begin
                        aborted_d = aborted_q | abort_i;
                        state_d   = ST_DRAIN;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else if (abort_i) begin
                    // A visible request must still complete its handshake.
                    aborted_d = 1'b1;
                    if (!req_valid) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort_i) begin
                    aborted_d = 1'b1;
                end
                if (outst_q == 5'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            burst_q   <= BURST_FIXED;
            addr_q    <= '0;
            raddr_q   <= '0;
            bytes_q   <= '0;
            bt_q      <= '0;
            maxb_q    <= '0;
            alen_q    <= '0;
            first_q   <= '0;
            last_q    <= '0;
            outst_q   <= '0;
            mode_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            addr_q    <= addr_d;
            raddr_q   <= raddr_d;
            bytes_q   <= bytes_d;
            bt_q      <= bt_d;
            maxb_q    <= maxb_d;
            alen_q    <= alen_d;
            first_q   <= first_d;
            last_q    <= last_d;
            outst_q   <= outst_d;
            mode_q    <= mode_d;
            aborted_q <= aborted_d;
        end
    end

    assign start_ready_o        = (state_q == ST_IDLE);
    assign req_m.req_valid      = req_valid;
    assign req_m.req_addr       = raddr_q;
    assign req_m.req_alen       = alen_q;
    assign req_m.req_size       = 3'(LG);
    assign req_m.req_burst      = burst_q;
    assign req_m.req_write      = (STREAM_TYPE != 0);
    assign req_m.req_first_strb = first_q;
    assign req_m.req_last_strb  = last_q;
    assign outst_o              = outst_q;
    assign done_o               = (state_q == ST_DRAIN) && (outst_q == 5'd0);
    assign aborted_o            = done_o && aborted_q;

    txn_done_underflow: assert property (@(posedge clk) disable iff (rst)
        txn_done_i |-> (outst_q != 5'd0));

endmodule

// File: tb/tb_dma_burst_gen.sv
// tb/tb_dma_burst_gen.sv - scoreboard bench for dma_burst_gen
module tb_dma_burst_gen;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = 32;
    localparam int MO = 2;

    logic          clk;
    logic          rst;
    logic          start_valid_i;
    logic          start_ready_o;
    logic [AW-1:0] start_addr_i;
    logic [BW-1:0] start_bytes_i;
    logic          start_mode_i;
    logic [7:0]    maxb_i;
    logic          abort_i;
    logic          txn_done_i;
    logic [4:0]    outst_o;
    logic          done_o;
    logic          aborted_o;

    dma_burst_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) req_if ();

    dma_burst_gen #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .BYTES_WIDTH (BW),
        .MAX_OUTST   (MO),
        .STREAM_TYPE (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_valid_i (start_valid_i),
        .start_ready_o (start_ready_o),
        .start_addr_i  (start_addr_i),
        .start_bytes_i (start_bytes_i),
        .start_mode_i  (start_mode_i),
        .maxb_i        (maxb_i),
        .abort_i       (abort_i),
        .req_m         (req_if),
        .txn_done_i    (txn_done_i),
        .outst_o       (outst_o),
        .done_o        (done_o),
        .aborted_o     (aborted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  alen;
        logic [1:0]  burst;
        logic [3:0]  first;
        logic [3:0]  last;
    } req_t;

    req_t exp_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   acc_cnt   = 0;
    int   pend      = 0;
    int   max_outst = 0;
    bit   auto_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                            input logic [3:0] f, input logic [3:0] la);
        req_t e;
        e.addr = a; e.alen = l; e.burst = b; e.first = f; e.last = la;
        exp_q.push_back(e);
    endtask

    // Beat-by-beat walk: grow a burst until bytes, maxb+1 beats or a 4 KB line run out.
    task automatic model_incr(input logic [31:0] a, input logic [31:0] n, input logic [7:0] mb);
        logic [31:0] ptr, nb, rem, fb, lb;
        logic [1:0]  off;
        int          beats;
        req_t        e;
        while (n != 0) begin
            off   = a[1:0];
            fb    = (n < 32'(4 - off)) ? n : 32'(4 - off);
            nb    = fb;
            rem   = n - fb;
            ptr   = {a[31:2], 2'b00} + 32'd4;
            beats = 1;
            while (rem != 0 && beats < int'(mb) + 1 && ptr[11:0] != 12'h000) begin
                lb    = (rem < 32'd4) ? rem : 32'd4;
                rem   = rem - lb;
                nb    = nb + lb;
                ptr   = ptr + 32'd4;
                beats = beats + 1;
            end
            e.addr  = {a[31:2], 2'b00};
            e.alen  = 8'(beats - 1);
            e.burst = 2'b01;
            e.first = 4'(((32'd1 << fb) - 32'd1) << off);
            if (beats == 1) begin
                e.last = e.first;
            end else begin
                lb = (32'(off) + nb) % 32'd4;
                if (lb == 0) lb = 32'd4;
                e.last = 4'((32'd1 << lb) - 32'd1);
            end
            exp_q.push_back(e);
            a = a + nb;
            n = n - nb;
        end
    endtask

    // Request monitor and completion responder, sampling just after the falling edge.
    initial begin
        req_t e;
        txn_done_i = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pend       = 0;
                txn_done_i = 1'b0;
            end else begin
                if (txn_done_i) begin
                    txn_done_i = 1'b0;
                end else if (auto_done && pend > 0) begin
                    txn_done_i = 1'b1;
                    pend--;
                end
                if (req_if.req_valid && req_if.req_ready) begin
                    acc_cnt++;
                    pend++;
                    check("req_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("req_addr", req_if.req_addr, e.addr);
                        check("req_alen", req_if.req_alen, e.alen);
                        check("req_burst", req_if.req_burst, e.burst);
                        check("req_first_strb", req_if.req_first_strb, e.first);
                        check("req_last_strb", req_if.req_last_strb, e.last);
                        check("req_size", req_if.req_size, 3'd2);
                    end
                end
                if (int'(outst_o) > max_outst) max_outst = int'(outst_o);
            end
        end
    end

    task automatic start_desc(input logic [31:0] a, input logic [31:0] n, input logic m,
                              input logic [7:0] mb);
        int t = 0;
        @(negedge clk);
        while (!start_ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("start_ready", start_ready_o, 1'b1);
        start_addr_i  = a;
        start_bytes_i = n;
        start_mode_i  = m;
        maxb_i        = mb;
        start_valid_i = 1'b1;
        @(negedge clk);
        start_valid_i = 1'b0;
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!req_if.req_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("valid_seen", req_if.req_valid, 1'b1);
    endtask

    task automatic wait_done(input logic exp_ab);
        int t = 0;
        while (!done_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", done_o, 1'b1);
        check("aborted", aborted_o, exp_ab);
        check("outst_at_done", outst_o, 5'd0);
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int t;
        int dcnt;
        rst = 1'b1; start_valid_i = 1'b0; start_addr_i = '0; start_bytes_i = '0;
        start_mode_i = 1'b0; maxb_i = '0; abort_i = 1'b0; req_if.req_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_start_ready", start_ready_o, 1'b1);
        check("rst_valid", req_if.req_valid, 1'b0);
        check("rst_size", req_if.req_size, 3'd2);
        check("rst_outst", outst_o, 5'd0);
        check("rst_done", done_o, 1'b0);
        check("rst_addr", req_if.req_addr, 32'h0);

        req_if.req_ready = 1'b1;
        auto_done = 1'b1;

        // Aligned 64 B INCR: one 16-beat burst, two-cycle start latency.
        push_exp(32'h1000, 8'd15, 2'b01, 4'hF, 4'hF);
        start_desc(32'h1000, 32'd64, 1'b0, 8'd255);
        check("lat_calc", req_if.req_valid, 1'b0);
        @(negedge clk);
        check("lat_issue", req_if.req_valid, 1'b1);
        wait_done(1'b0);

        // Unaligned head and tail folded into one burst.
        push_exp(32'h1000, 8'd3, 2'b01, 4'h8, 4'h1);
        start_desc(32'h1003, 32'd10, 1'b0, 8'd255);
        wait_done(1'b0);

        // 4 KB crossing splits the burst.
        push_exp(32'h0FF0, 8'd3, 2'b01, 4'hF, 4'hF);
        push_exp(32'h1000, 8'd11, 2'b01, 4'hF, 4'hF);
        start_desc(32'h0FF0, 32'd64, 1'b0, 8'd255);
        wait_done(1'b0);

        // Modelled INCR mixes: partial heads, maxb limit, 4 KB limit, single beat.
        model_incr(32'h0FFE, 32'd40, 8'd2);
        start_desc(32'h0FFE, 32'd40, 1'b0, 8'd2);
        wait_done(1'b0);
        model_incr(32'h1001, 32'd3, 8'd255);
        start_desc(32'h1001, 32'd3, 1'b0, 8'd255);
        wait_done(1'b0);
        model_incr(32'h2FF5, 32'd100, 8'd7);
        start_desc(32'h2FF5, 32'd100, 1'b0, 8'd7);
        wait_done(1'b0);

        // Outstanding limit: third request held until a completion.
        for (int i = 0; i < 4; i++) push_exp(32'h3000 + 32'(4 * i), 8'd0, 2'b01, 4'hF, 4'hF);
        auto_done = 1'b0;
        base = acc_cnt;
        start_desc(32'h3000, 32'd16, 1'b0, 8'd0);
        t = 0;
        while (acc_cnt < base + 2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        check("held_valid_low", req_if.req_valid, 1'b0);
        check("held_outst", outst_o, 5'd2);
        check("held_accepts", acc_cnt - base, 2);
        auto_done = 1'b1;
        wait_done(1'b0);

        // FIXED: 16-beat burst then a 2-beat tail at the same address.
        push_exp(32'h2000, 8'd15, 2'b00, 4'hF, 4'hF);
        push_exp(32'h2000, 8'd1, 2'b00, 4'hF, 4'hF);
        start_desc(32'h2000, 32'd72, 1'b1, 8'd255);
        wait_done(1'b0);

        // Zero-byte descriptor completes without requests.
        base = acc_cnt;
        start_desc(32'h1234, 32'd0, 1'b0, 8'd255);
        wait_done(1'b0);
        check("zero_no_req", acc_cnt - base, 0);

        // Abort with a request pending: it completes, nothing further is issued.
        req_if.req_ready = 1'b0;
        push_exp(32'h4000, 8'd3, 2'b01, 4'hF, 4'hF);
        base = acc_cnt;
        start_desc(32'h4000, 32'd64, 1'b0, 8'd3);
        wait_valid();
        abort_i = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_valid_held", req_if.req_valid, 1'b1);
        req_if.req_ready = 1'b1;
        @(negedge clk);
        req_if.req_ready = 1'b0;
        wait_done(1'b1);
        abort_i = 1'b0;
        check("abort_one_req", acc_cnt - base, 1);

        // Reset in the middle of ISSUE.
        start_desc(32'h5000, 32'd16, 1'b0, 8'd0);
        wait_valid();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", req_if.req_valid, 1'b0);
        check("mid_rst_start_ready", start_ready_o, 1'b1);
        check("mid_rst_outst", outst_o, 5'd0);
        check("mid_rst_addr", req_if.req_addr, 32'h0);
        check("mid_rst_alen", req_if.req_alen, 8'h0);
        check("mid_rst_strb", {req_if.req_first_strb, req_if.req_last_strb}, 8'h00);
        check("mid_rst_burst", req_if.req_burst, 2'b00);
        check("mid_rst_size", req_if.req_size, 3'd2);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_o) dcnt++;
        end
        check("no_done_after_rst", dcnt, 0);

        check("max_outst", max_outst, MO);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
